eth_rx_frame_writer: RTL and testbench
======================================

Name: eth_rx_frame_writer

Overview:
Upstream neighbour of the RX frame buffer. Accepts the byte stream from the Ethernet MAC receive path, writes each byte into the 2 KiB RX buffer's byte-wide write port with ascending byte addresses from 0, and validates the frame (length, error flag). Hands each good frame to the bus-side reader through a valid/release ownership handshake; frames that arrive while the buffer is owned, or that are bad, are discarded and counted.

Parameters:
MaxFrameBytes, 1522, largest accepted frame including FCS; must be <= 2048.
MinFrameBytes, 64, smallest accepted frame including FCS; must be >= 1.
DropCntWidth, 16, width of the saturating drop counter.

Ports:
clk_i  in  1  clock; the MAC stream and buffer write port share this domain.
rst_ni  in  1  asynchronous active-low reset.
rx_valid_i  in  1  byte strobe from MAC; no backpressure, gaps allowed.
rx_data_i  in  8  received byte.
rx_sof_i  in  1  qualifies the first byte of a frame (valid only with rx_valid_i).
rx_eof_i  in  1  qualifies the last byte of a frame (valid only with rx_valid_i).
rx_err_i  in  1  frame error (FCS/PHY); sampled only on the eof byte.
buf_we_o  out  1  buffer write enable.
buf_en_o  out  1  buffer port enable; equal to buf_we_o.
buf_addr_o  out  11  buffer byte address.
buf_data_o  out  8  buffer write byte.
frame_valid_o  out  1  a complete good frame is in the buffer and owned by the reader.
frame_len_o  out  12  byte length of the owned frame; stable while frame_valid_o.
frame_release_i  in  1  reader returns the buffer; honoured only while frame_valid_o.
drop_o  out  1  one-cycle pulse for each discarded frame.
drop_cnt_o  out  DropCntWidth  saturating count of discarded frames.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte counter 0.
- States: IDLE (buffer free), RECV (writing), DROP (discarding to eof), COMMIT (write drain), READY (reader owns buffer).
- IDLE: valid+sof -> write byte at addr 0, count=1, go RECV. If eof on the same byte, evaluate the frame immediately, as for RECV eof. Valid without sof: ignore, no drop.
- RECV: each valid byte is written at addr=count; count increments.
  - Byte pushing count past MaxFrameBytes: not written; go DROP; drop is counted when eof arrives.
  - Valid+sof (missing eof): count a drop for the old frame and restart at addr 0 with this byte.
  - Valid+eof: final length L=count incl. this byte. L<MinFrameBytes or rx_err_i=1 -> drop, go IDLE. Otherwise go COMMIT.
- Buffer write latency: registered; the byte accepted in cycle N appears on buf_* in cycle N+1 with buf_we_o=buf_en_o=1 for exactly one cycle. Otherwise buf_we_o=buf_en_o=0.
- COMMIT: one cycle, covering the final write; then READY. frame_valid_o rises in cycle N+2 after the eof byte in cycle N. frame_len_o=L.
- DROP: ignore bytes until valid+eof, then pulse drop_o, go IDLE. A sof in DROP restarts as in the IDLE rule, after counting the pending drop.
- READY: incoming bytes are never written. A valid+sof starts a discarded frame: the frame is tracked as DROP-within-READY until eof, then drop_o pulses. frame_valid_o stays 1 until release.
- Release: frame_valid_o falls the next cycle and the state goes IDLE. If a foreign frame is mid-discard, the state goes DROP instead.
- Release and sof in the same cycle: the sof frame is discarded, because the buffer is still owned that cycle.
- frame_release_i while not frame_valid_o: ignored.
- drop_cnt_o saturates at all-ones. drop_o pulses in the cycle after the terminating eof or sof.
- Reset mid-frame: immediate return to IDLE. A partial frame is never presented, and no write strobe is produced after reset assertion.

Test Plan:
- 64-byte good frame, bytes 0x00..0x3F, sof on first, eof on last, no gaps: buf writes addr 0..63 with data=addr, one cycle after each byte; frame_valid_o rises 2 cycles after eof; frame_len_o=64.
- Same frame with random 0-3 cycle valid gaps, then frame_release_i pulse: identical writes; frame_valid_o falls the cycle after release; a second 100-byte frame is then accepted with frame_len_o=100.
- 60-byte runt, then a 64-byte frame with rx_err_i=1 at eof: no frame_valid_o; drop_o pulses twice; drop_cnt_o=2; the state is back to IDLE.
- 1600-byte frame: writes stop after addr 1521; drop on eof; drop_cnt_o=1; no frame_valid_o.
- Frame held in READY while a 64-byte frame arrives, with release coincident with that frame's sof: no buf writes for the arriving frame; drop_cnt_o +1; the next frame is accepted normally.
- Force drop_cnt_o to 0xFFFE and drop 3 frames: the counter saturates at 0xFFFF. Assert rst_ni low mid-frame at byte 30: outputs 0 at once; after release of reset, a new frame is written from addr 0.

Source files
------------

// File: rtl/eth_rx_frame_writer_if.sv
// Bundle of MAC receive stream, RX buffer write port, reader ownership handshake and drop reporting.
// master = frame writer, slave = its environment (MAC, buffer and reader side).
interface eth_rx_frame_writer_if #(
    parameter int DropCntWidth = 16
);
    logic                    rx_valid_i;
    logic [7:0]              rx_data_i;
    logic                    rx_sof_i;
    logic                    rx_eof_i;
    logic                    rx_err_i;

    logic                    buf_we_o;
    logic                    buf_en_o;
    logic [10:0]             buf_addr_o;
    logic [7:0]              buf_data_o;

    // Ownership handshake: frame_valid_o high means the reader owns the buffer and
    // frame_len_o is stable; a one-cycle frame_release_i while frame_valid_o is high
    // hands the buffer back and frame_valid_o drops in the next cycle. A release
    // while frame_valid_o is low has no effect. The MAC stream has no backpressure.
    logic                    frame_valid_o;
    logic [11:0]             frame_len_o;
    logic                    frame_release_i;

    logic                    drop_o;
    logic [DropCntWidth-1:0] drop_cnt_o;
    logic [2:0]              state_o;

    modport master (
        input  rx_valid_i, rx_data_i, rx_sof_i, rx_eof_i, rx_err_i, frame_release_i,
        output buf_we_o, buf_en_o, buf_addr_o, buf_data_o,
        output frame_valid_o, frame_len_o, drop_o, drop_cnt_o, state_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, rx_sof_i, rx_eof_i, rx_err_i, frame_release_i,
        input  buf_we_o, buf_en_o, buf_addr_o, buf_data_o,
        input  frame_valid_o, frame_len_o, drop_o, drop_cnt_o, state_o
    );
endinterface

// File: rtl/eth_rx_frame_writer.sv
// Writes MAC receive bytes into the RX buffer, validates each frame and hands good
// frames to the reader; discarded frames are pulsed on drop_o and counted.
module eth_rx_frame_writer #(
    parameter int MaxFrameBytes = 1522,
    parameter int MinFrameBytes = 64,
    parameter int DropCntWidth  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    eth_rx_frame_writer_if.master  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RECV   = 3'd1;
    localparam logic [2:0] DROP   = 3'd2;
    localparam logic [2:0] COMMIT = 3'd3;
    localparam logic [2:0] READY  = 3'd4;

    localparam logic [11:0] MAX_LEN = 12'(MaxFrameBytes);
    localparam logic [11:0] MIN_LEN = 12'(MinFrameBytes);

    logic [2:0]              state_q, state_d;
    logic [11:0]             cnt_q, cnt_d;
    logic                    foreign_q, foreign_d;
    logic                    we_q, we_d;
    logic [10:0]             addr_q, addr_d;
    logic [7:0]              data_q, data_d;
    logic [11:0]             len_q, len_d;
    logic                    drop_q, drop_d;
    logic [DropCntWidth-1:0] dcnt_q, dcnt_d;

    logic                    start;
    logic                    eval;
    logic [11:0]             eval_len;
    logic [1:0]              drop_inc;
    logic [DropCntWidth:0]   dcnt_sum;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        foreign_d = foreign_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        len_d     = len_q;
        start     = 1'b0;
        eval      = 1'b0;
        eval_len  = 12'd0;
        drop_inc  = 2'd0;

        case (state_q)
            IDLE: begin
                if (bus.rx_valid_i && bus.rx_sof_i) start = 1'b1;
            end
            RECV: begin
                if (bus.rx_valid_i) begin
                    if (bus.rx_sof_i) begin
                        drop_inc = 2'd1;
                        start    = 1'b1;
                    end else if (cnt_q >= MAX_LEN) begin
                        // Oversized: nothing more is written, the drop is reported at eof.
                        if (bus.rx_eof_i) begin
                            drop_inc = 2'd1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = DROP;
                        end
                    end else begin
                        we_d   = 1'b1;
                        addr_d = cnt_q[10:0];
                        data_d = bus.rx_data_i;
                        cnt_d  = cnt_q + 12'd1;
                        if (bus.rx_eof_i) begin
                            eval     = 1'b1;
                            eval_len = cnt_q + 12'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.rx_valid_i) begin
                    if (bus.rx_sof_i) begin
                        drop_inc = 2'd1;
                        start    = 1'b1;
                    end else if (bus.rx_eof_i) begin
                        drop_inc = 2'd1;
                        state_d  = IDLE;
                    end
                end
            end
            COMMIT, READY: begin
                // Buffer is owned: arriving frames are only tracked so they can be counted.
                if (bus.rx_valid_i) begin
                    if (bus.rx_sof_i) begin
                        drop_inc  = {1'b0, foreign_q} + {1'b0, bus.rx_eof_i};
                        foreign_d = ~bus.rx_eof_i;
                    end else if (foreign_q && bus.rx_eof_i) begin
                        drop_inc  = 2'd1;
                        foreign_d = 1'b0;
                    end
                end
                if (state_q == COMMIT) begin
                    state_d = READY;
                end else if (bus.frame_release_i) begin
                    state_d   = foreign_d ? DROP : IDLE;
                    foreign_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            we_d    = 1'b1;
            addr_d  = 11'd0;
            data_d  = bus.rx_data_i;
            cnt_d   = 12'd1;
            state_d = RECV;
            if (bus.rx_eof_i) begin
                eval     = 1'b1;
                eval_len = 12'd1;
            end
        end

        if (eval) begin
            if (eval_len < MIN_LEN || bus.rx_err_i) begin
                drop_inc = drop_inc + 2'd1;
                state_d  = IDLE;
            end else begin
                len_d   = eval_len;
                state_d = COMMIT;
            end
        end
    end

    assign dcnt_sum = {1'b0, dcnt_q} + (DropCntWidth+1)'(drop_inc);
    assign dcnt_d   = dcnt_sum[DropCntWidth] ? {DropCntWidth{1'b1}} : dcnt_sum[DropCntWidth-1:0];
    assign drop_d   = (drop_inc != 2'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 12'd0;
            foreign_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 11'd0;
            data_q    <= 8'd0;
            len_q     <= 12'd0;
            drop_q    <= 1'b0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            foreign_q <= foreign_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            len_q     <= len_d;
            drop_q    <= drop_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign bus.buf_we_o      = we_q;
    assign bus.buf_en_o      = we_q;
    assign bus.buf_addr_o    = addr_q;
    assign bus.buf_data_o    = data_q;
    assign bus.frame_valid_o = (state_q == READY);
    assign bus.frame_len_o   = len_q;
    assign bus.drop_o        = drop_q;
    assign bus.drop_cnt_o    = dcnt_q;
    assign bus.state_o       = state_q;
endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Randomized bench for eth_rx_frame_writer: a frame-level model predicts buffer writes,
// frame hand-overs and drops with their cycles; a negedge monitor checks them.
module tb_eth_rx_frame_writer;
    localparam int MAX = 1522;
    localparam int MIN = 64;
    localparam int DCW = 8;
    localparam int SAT = (1 << DCW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;

    eth_rx_frame_writer_if #(.DropCntWidth(DCW)) bus ();

    eth_rx_frame_writer #(
        .MaxFrameBytes(MAX),
        .MinFrameBytes(MIN),
        .DropCntWidth (DCW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [50:0] exp_wr_q[$];    // {cycle, addr, data}
    logic [43:0] exp_len_q[$];   // {cycle, len}
    logic [39:0] exp_drop_q[$];  // {cycle, drop count after this drop}
    int          m_drops = 0;
    bit          owned = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got unexpected event %0h expected none (cycle %0d)", nm, act, cyc);
    endtask

    task automatic push_drop(input int unsigned c);
        int sat;
        m_drops++;
        sat = (m_drops > SAT) ? SAT : m_drops;
        exp_drop_q.push_back({c, 8'(sat)});
    endtask

    // driver tasks
    task automatic idle_n(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.rx_valid_i      = 1'b0;
            bus.rx_sof_i        = 1'b0;
            bus.rx_eof_i        = 1'b0;
            bus.frame_release_i = 1'b0;
        end
    endtask

    // Frame fate is decided at its sof: owned buffer or bad length/error means discard.
    task automatic send_frame(input int len, input bit err, input int gap_max,
                              input int rel_idx, input bit pattern);
        bit          was_owned;
        logic [7:0]  b;
        int unsigned c;
        was_owned = owned;
        for (int i = 0; i < len; i++) begin
            if (i > 0 && gap_max > 0) idle_n($urandom_range(0, gap_max));
            @(posedge clk); #1;
            b = pattern ? 8'(i) : 8'($urandom_range(0, 255));
            bus.rx_valid_i      = 1'b1;
            bus.rx_data_i       = b;
            bus.rx_sof_i        = (i == 0);
            bus.rx_eof_i        = (i == len - 1);
            bus.rx_err_i        = (i == len - 1) ? err : 1'($urandom_range(0, 1));
            bus.frame_release_i = (i == rel_idx);
            c = cyc;
            if (!was_owned && i < MAX) exp_wr_q.push_back({c + 32'd1, 11'(i), b});
            if (i == rel_idx) owned = 1'b0;
            if (i == len - 1) begin
                if (was_owned || len > MAX || len < MIN || err) begin
                    push_drop(c + 32'd1);
                end else begin
                    exp_len_q.push_back({c + 32'd2, 12'(len)});
                    owned = 1'b1;
                end
            end
        end
        idle_n(1);
    endtask

    task automatic rel_frame();
        for (int k = 0; k < 20 && !bus.frame_valid_o; k++) begin
            @(posedge clk); #1;
        end
        check("release_wait_valid", bus.frame_valid_o, 1);
        @(posedge clk); #1;
        bus.frame_release_i = 1'b1;
        owned = 1'b0;
        idle_n(1);
    endtask

    task automatic spurious_release();
        @(posedge clk); #1;
        bus.frame_release_i = 1'b1;
        idle_n(1);
    endtask

    // monitor
    bit          fv_prev = 1'b0;
    bit          rel_prev = 1'b0;
    logic [11:0] cur_len = 12'd0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n) begin
            fv_prev  = 1'b0;
            rel_prev = 1'b0;
        end else begin
            if (bus.buf_we_o) begin
                check("buf_en", bus.buf_en_o, 1);
                if (exp_wr_q.size() == 0) unexpected("buf_write", {bus.buf_addr_o, bus.buf_data_o});
                else check("buf_write", {cyc, bus.buf_addr_o, bus.buf_data_o}, exp_wr_q.pop_front());
            end else if (bus.buf_en_o) begin
                unexpected("buf_en_alone", bus.buf_addr_o);
            end
            if (bus.frame_valid_o && !fv_prev) begin
                if (exp_len_q.size() == 0) unexpected("frame_valid_rise", bus.frame_len_o);
                else begin
                    e = exp_len_q.pop_front();
                    cur_len = e[11:0];
                    check("frame_valid_rise", {cyc, bus.frame_len_o}, e);
                end
            end else if (bus.frame_valid_o) begin
                check("frame_len_stable", bus.frame_len_o, cur_len);
            end
            if (fv_prev && rel_prev) check("frame_valid_fall", bus.frame_valid_o, 0);
            else if (fv_prev && !bus.frame_valid_o) unexpected("frame_valid_fall", 0);
            if (bus.drop_o) begin
                if (exp_drop_q.size() == 0) unexpected("drop", bus.drop_cnt_o);
                else check("drop", {cyc, bus.drop_cnt_o}, exp_drop_q.pop_front());
            end
            fv_prev  = bus.frame_valid_o;
            rel_prev = bus.frame_release_i;
        end
    end

    task automatic check_outputs_zero(input string nm);
        check({nm, "_we"},    bus.buf_we_o, 0);
        check({nm, "_en"},    bus.buf_en_o, 0);
        check({nm, "_addr"},  bus.buf_addr_o, 0);
        check({nm, "_data"},  bus.buf_data_o, 0);
        check({nm, "_valid"}, bus.frame_valid_o, 0);
        check({nm, "_len"},   bus.frame_len_o, 0);
        check({nm, "_drop"},  bus.drop_o, 0);
        check({nm, "_cnt"},   bus.drop_cnt_o, 0);
        check({nm, "_state"}, bus.state_o, 0);
    endtask

    task automatic check_drop_cnt(input string nm);
        check(nm, bus.drop_cnt_o, (m_drops > SAT) ? SAT : m_drops);
    endtask

    // main sequence
    initial begin
        int len;
        int rel;
        bus.rx_valid_i      = 1'b0;
        bus.rx_data_i       = 8'd0;
        bus.rx_sof_i        = 1'b0;
        bus.rx_eof_i        = 1'b0;
        bus.rx_err_i        = 1'b0;
        bus.frame_release_i = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_n(2);

        // good frames: back-to-back, then with gaps, then 100 bytes
        send_frame(64, 1'b0, 0, -1, 1'b1);
        idle_n(2);
        rel_frame();
        send_frame(64, 1'b0, 3, -1, 1'b1);
        idle_n(2);
        rel_frame();
        send_frame(100, 1'b0, 1, -1, 1'b0);
        idle_n(2);
        rel_frame();

        // runt and errored frame
        send_frame(60, 1'b0, 0, -1, 1'b0);
        idle_n(2);
        send_frame(64, 1'b1, 0, -1, 1'b0);
        idle_n(4);
        check_drop_cnt("drop_cnt_bad_frames");
        check("state_idle_after_drops", bus.state_o, 0);

        // oversized frame
        send_frame(1600, 1'b0, 0, -1, 1'b1);
        idle_n(4);
        check_drop_cnt("drop_cnt_oversize");

        // owned buffer, release coincident with the arriving frame's sof
        send_frame(64, 1'b0, 0, -1, 1'b0);
        idle_n(3);
        send_frame(64, 1'b0, 0, 0, 1'b0);
        idle_n(2);
        send_frame(80, 1'b0, 0, -1, 1'b0);
        idle_n(2);
        rel_frame();

        // randomized traffic
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: len = $urandom_range(MIN, MIN + 60);
                6:                len = $urandom_range(1, MIN - 1);
                7:                len = $urandom_range(MAX - 1, MAX + 2);
                default:          len = $urandom_range(MIN, 200);
            endcase
            rel = (owned && $urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            send_frame(len, ($urandom_range(0, 7) == 0), $urandom_range(0, 2), rel, 1'b0);
            idle_n(2);
            if (owned && $urandom_range(0, 1) == 1) rel_frame();
            else if (!owned && $urandom_range(0, 3) == 0) spurious_release();
        end
        if (owned) rel_frame();
        idle_n(4);
        check_drop_cnt("drop_cnt_random");

        // counter saturation with single-byte runts
        for (int k = 0; k < SAT + 5; k++) send_frame(1, 1'b0, 0, -1, 1'b0);
        idle_n(4);
        check_drop_cnt("drop_cnt_saturated");

        // reset in the middle of a frame
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            bus.rx_valid_i = 1'b1;
            bus.rx_data_i  = 8'(i + 7);
            bus.rx_sof_i   = (i == 0);
            bus.rx_eof_i   = 1'b0;
            exp_wr_q.push_back({cyc + 32'd1, 11'(i), 8'(i + 7)});
        end
        idle_n(1);
        @(posedge clk); #1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'hA5;
        #1 rst_n = 1'b0;
        bus.rx_valid_i = 1'b0;
        #1;
        check_outputs_zero("mid_frame_reset");
        m_drops = 0;
        owned   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_n(1);
        send_frame(64, 1'b0, 1, -1, 1'b1);
        idle_n(2);
        rel_frame();
        idle_n(6);

        check("wr_queue_drained",   exp_wr_q.size(), 0);
        check("len_queue_drained",  exp_len_q.size(), 0);
        check("drop_queue_drained", exp_drop_q.size(), 0);
        check_drop_cnt("drop_cnt_final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
